// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, reset PC default and the {pc, instr} bundle type for the fetch stage.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_bundle_t;
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: sync FIFO of fetch bundles with flush; head holds the last popped entry when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_bundle_t                push_data,
  input  logic                         pop,
  output fetch_bundle_t                head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  fetch_bundle_t mem [DEPTH];
  fetch_bundle_t last_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_pop;
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign do_pop = pop && (count != '0);
  assign head = (count != '0) ? mem[rd_ptr] : last_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
        last_q <= mem[rd_ptr];
      end
      count <= count + CW'(push) - CW'(do_pop);
    end
  end
  // the issuer's credit accounting must never let a push land on a full buffer
  assert property (@(posedge clock) disable iff (!reset_n)
    !(push && !flush && !do_pop && count == CW'(DEPTH)));
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues imemory reads under a credit limit and buffers {pc, instr} for decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_data_in,
  output logic        imem_read_write,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  logic [31:0] pc_q, inflight_pc_q;
  logic inflight_q, pop, push, issue;
  logic [CW-1:0] count;
  fetch_bundle_t head;
  assign imem_addr       = pc_q;
  assign imem_data_in    = 32'h0;
  assign imem_read_write = 1'b0;
  assign out_valid = (count != '0) && !redirect_valid;
  assign pop       = out_valid && out_ready;
  assign push      = inflight_q && !redirect_valid;
  // slots already promised (buffered + in flight) after this cycle's pop must leave room
  assign issue = !redirect_valid && (int'(count) + int'(inflight_q) - int'(pop) < BUF_DEPTH);
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (redirect_valid) begin
      pc_q       <= align_pc(redirect_pc);
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= pc_q;
        pc_q          <= pc_q + 32'(INSTR_BYTES);
      end
    end
  end
  fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ('{pc: inflight_pc_q, instr: imem_rdata}),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );
endmodule
